// File: rtl/cpu7_exu_eclwbpipe.sv
// E->M->W destination / write-enable pipe with load-use detection and a saturating stall counter.
// Optional multi-cycle LSU wait in M is compiled in by defining CPU7_LSU_MULTICYCLE_EN.
module cpu7_exu_eclwbpipe (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_e,
    input  logic [4:0]  rd_e,
    input  logic        wen_e,
    input  logic        load_e,
    input  logic        flush_e,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic        rs1_use_d,
    input  logic        rs2_use_d,
    input  logic        lsu_data_vld_m,
    output logic [4:0]  rd_m,
    output logic [4:0]  rd_w,
    output logic        wen_m,
    output logic        wen_w,
    output logic        load_m,
    output logic        stall_d,
    output logic        stall_e,
    output logic [15:0] lu_cnt
);

    logic        e_live;
    logic        load_use;
    logic        adv_m;
    logic [4:0]  rd_m_q;
    logic [4:0]  rd_w_q;
    logic        wen_m_q;
    logic        wen_w_q;
    logic        load_m_q;
    logic [15:0] lu_cnt_q;
    logic [15:0] lu_cnt_d;

    assign e_live   = valid_e & ~flush_e;
    assign load_use = e_live & load_e & (rd_e != 5'd0) &
                      ((rs1_use_d & (rs1_d == rd_e)) | (rs2_use_d & (rs2_d == rd_e)));

`ifdef CPU7_LSU_MULTICYCLE_EN
    // state    | meaning
    // RUN      | M advances every cycle; a load without data stalls and moves to WAIT_LSU
    // WAIT_LSU | load held in M until lsu_data_vld_m; the exit cycle itself does not stall
    typedef enum logic {
        RUN      = 1'b0,
        WAIT_LSU = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   stall_e_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_e_c = 1'b0;
        case (state_q)
            RUN: begin
                if (load_m_q & ~lsu_data_vld_m) begin
                    state_d   = WAIT_LSU;
                    stall_e_c = 1'b1;
                end
            end
            WAIT_LSU: begin
                if (lsu_data_vld_m) begin
                    state_d = RUN;
                end else begin
                    stall_e_c = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_e = stall_e_c;
`else
    logic unused_lsu_data_vld;
    assign unused_lsu_data_vld = lsu_data_vld_m;
    assign stall_e             = 1'b0;
`endif

    assign adv_m   = ~stall_e;
    assign stall_d = load_use | stall_e;

    // A held M inserts a bubble into W; rd_w keeps its last value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_m_q   <= 5'd0;
            wen_m_q  <= 1'b0;
            load_m_q <= 1'b0;
            rd_w_q   <= 5'd0;
            wen_w_q  <= 1'b0;
        end else if (adv_m) begin
            rd_m_q   <= rd_e;
            wen_m_q  <= wen_e & e_live & (rd_e != 5'd0);
            load_m_q <= load_e & e_live;
            rd_w_q   <= rd_m_q;
            wen_w_q  <= wen_m_q;
        end else begin
            wen_w_q  <= 1'b0;
        end
    end

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (load_use & ~stall_e & (lu_cnt_q != 16'hFFFF)) begin
            lu_cnt_d = lu_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lu_cnt_q <= 16'd0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign rd_m   = rd_m_q;
    assign wen_m  = wen_m_q;
    assign load_m = load_m_q;
    assign rd_w   = rd_w_q;
    assign wen_w  = wen_w_q;
    assign lu_cnt = lu_cnt_q;

endmodule

// File: tb/tb_cpu7_exu_eclwbpipe.sv
// Self-checking bench for cpu7_exu_eclwbpipe; writebacks are scoreboarded through exp_q.
// The LSU-wait scenarios are exercised when CPU7_LSU_MULTICYCLE_EN is defined.
module tb_cpu7_exu_eclwbpipe;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid_e = 1'b0;
    logic [4:0]  rd_e = 5'd0;
    logic        wen_e = 1'b0;
    logic        load_e = 1'b0;
    logic        flush_e = 1'b0;
    logic [4:0]  rs1_d = 5'd0;
    logic [4:0]  rs2_d = 5'd0;
    logic        rs1_use_d = 1'b0;
    logic        rs2_use_d = 1'b0;
    logic        lsu_data_vld_m = 1'b1;
    logic [4:0]  rd_m;
    logic [4:0]  rd_w;
    logic        wen_m;
    logic        wen_w;
    logic        load_m;
    logic        stall_d;
    logic        stall_e;
    logic [15:0] lu_cnt;

    int          n_pass = 0;
    int          n_chk  = 0;
    logic [4:0]  exp_q[$];
    logic [15:0] exp_lu = 16'd0;

    typedef struct {
        logic       u1;
        logic [4:0] r1;
        logic       u2;
        logic [4:0] r2;
        logic [4:0] rd;
        logic       fl;
        logic       stall;
    } lu_case_t;

    lu_case_t lu_cases[6];

    cpu7_exu_eclwbpipe dut (
        .clk            (clk),
        .resetn         (resetn),
        .valid_e        (valid_e),
        .rd_e           (rd_e),
        .wen_e          (wen_e),
        .load_e         (load_e),
        .flush_e        (flush_e),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rs1_use_d      (rs1_use_d),
        .rs2_use_d      (rs2_use_d),
        .lsu_data_vld_m (lsu_data_vld_m),
        .rd_m           (rd_m),
        .rd_w           (rd_w),
        .wen_m          (wen_m),
        .wen_w          (wen_w),
        .load_m         (load_m),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .lu_cnt         (lu_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_e();
        valid_e   = 1'b0;
        wen_e     = 1'b0;
        load_e    = 1'b0;
        flush_e   = 1'b0;
        rd_e      = 5'd0;
        rs1_use_d = 1'b0;
        rs2_use_d = 1'b0;
    endtask

    task automatic test_reset();
        idle_e();
        resetn = 1'b0;
        #12;
        n_chk++;
        if ({rd_m, rd_w, wen_m, wen_w, load_m, lu_cnt} !== 29'd0)
            $display("FAIL reset_state: got rd_m=%0d rd_w=%0d wen_m=%0b wen_w=%0b load_m=%0b lu_cnt=%0h expected all zero",
                     rd_m, rd_w, wen_m, wen_w, load_m, lu_cnt);
        else n_pass++;
        n_chk++;
        if (stall_e !== 1'b0 || stall_d !== 1'b0)
            $display("FAIL reset_stall: got stall_e=%0b stall_d=%0b expected 0 0", stall_e, stall_d);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        exp_lu = 16'd0;
    endtask

    task automatic test_basic();
        valid_e = 1'b1; wen_e = 1'b1; rd_e = 5'd5;
        tick();
        valid_e = 1'b0; wen_e = 1'b0; rd_e = 5'd0;
        n_chk++;
        if (rd_m !== 5'd5 || wen_m !== 1'b1)
            $display("FAIL basic_m: got rd_m=%0d wen_m=%0b expected 5 1", rd_m, wen_m);
        else n_pass++;
        tick();
        n_chk++;
        if (rd_w !== 5'd5 || wen_w !== 1'b1 || wen_m !== 1'b0)
            $display("FAIL basic_w: got rd_w=%0d wen_w=%0b wen_m=%0b expected 5 1 0", rd_w, wen_w, wen_m);
        else n_pass++;
    endtask

    task automatic test_rd0();
        valid_e = 1'b1; wen_e = 1'b1; rd_e = 5'd0;
        tick();
        valid_e = 1'b0; wen_e = 1'b0;
        n_chk++;
        if (wen_m !== 1'b0) $display("FAIL rd0_m: got wen_m=%0b expected 0", wen_m);
        else n_pass++;
        tick();
        n_chk++;
        if (wen_w !== 1'b0) $display("FAIL rd0_w: got wen_w=%0b expected 0", wen_w);
        else n_pass++;
    endtask

    task automatic test_load_use();
        lu_cases[0] = '{u1: 1'b0, r1: 5'd0, u2: 1'b1, r2: 5'd7, rd: 5'd7, fl: 1'b0, stall: 1'b1};
        lu_cases[1] = '{u1: 1'b0, r1: 5'd0, u2: 1'b1, r2: 5'd8, rd: 5'd7, fl: 1'b0, stall: 1'b0};
        lu_cases[2] = '{u1: 1'b1, r1: 5'd7, u2: 1'b0, r2: 5'd0, rd: 5'd7, fl: 1'b0, stall: 1'b1};
        lu_cases[3] = '{u1: 1'b0, r1: 5'd7, u2: 1'b0, r2: 5'd7, rd: 5'd7, fl: 1'b0, stall: 1'b0};
        lu_cases[4] = '{u1: 1'b1, r1: 5'd0, u2: 1'b1, r2: 5'd0, rd: 5'd0, fl: 1'b0, stall: 1'b0};
        lu_cases[5] = '{u1: 1'b0, r1: 5'd0, u2: 1'b1, r2: 5'd7, rd: 5'd7, fl: 1'b1, stall: 1'b0};
        lsu_data_vld_m = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b1;
            rd_e = lu_cases[i].rd; flush_e = lu_cases[i].fl;
            rs1_use_d = lu_cases[i].u1; rs1_d = lu_cases[i].r1;
            rs2_use_d = lu_cases[i].u2; rs2_d = lu_cases[i].r2;
            #1;
            n_chk++;
            if (stall_d !== lu_cases[i].stall)
                $display("FAIL load_use_stall_d[%0d]: got %0b expected %0b", i, stall_d, lu_cases[i].stall);
            else n_pass++;
            tick();
            if (lu_cases[i].stall) exp_lu = exp_lu + 16'd1;
            n_chk++;
            if (lu_cnt !== exp_lu)
                $display("FAIL load_use_cnt[%0d]: got %0h expected %0h", i, lu_cnt, exp_lu);
            else n_pass++;
        end
        idle_e();
        tick();
        tick();
    endtask

    task automatic test_stream();
        logic [4:0] e;
        exp_q.delete();
        lsu_data_vld_m = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (i < 40) begin
                valid_e = 1'($urandom_range(0, 1));
                wen_e   = 1'($urandom_range(0, 1));
                flush_e = ($urandom_range(0, 3) == 0);
                rd_e    = 5'($urandom_range(0, 31));
            end else begin
                idle_e();
            end
            if (valid_e && wen_e && !flush_e && rd_e != 5'd0) exp_q.push_back(rd_e);
            tick();
            if (wen_w) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra_write: got rd_w=%0d expected no write", rd_w);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_w !== e) $display("FAIL stream_rd_w: got %0d expected %0d", rd_w, e);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL stream_missing_writes: got %0d left expected 0", exp_q.size());
        else n_pass++;
        n_chk++;
        if (lu_cnt !== exp_lu) $display("FAIL stream_lu_cnt: got %0h expected %0h", lu_cnt, exp_lu);
        else n_pass++;
    endtask

`ifdef CPU7_LSU_MULTICYCLE_EN
    task automatic test_lsu_wait();
        logic [4:0] e;
        exp_q.delete();
        valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b1; rd_e = 5'd3; lsu_data_vld_m = 1'b0;
        exp_q.push_back(5'd3);
        tick();
        idle_e();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (stall_e !== 1'b1 || stall_d !== 1'b1)
                $display("FAIL wait_stall[%0d]: got stall_e=%0b stall_d=%0b expected 1 1", i, stall_e, stall_d);
            else n_pass++;
            tick();
            n_chk++;
            if (wen_w !== 1'b0) $display("FAIL wait_bubble[%0d]: got wen_w=%0b expected 0", i, wen_w);
            else n_pass++;
        end
        lsu_data_vld_m = 1'b1;
        #1;
        n_chk++;
        if (stall_e !== 1'b0) $display("FAIL wait_exit_stall: got %0b expected 0", stall_e);
        else n_pass++;
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (rd_w !== e || wen_w !== 1'b1)
            $display("FAIL wait_retire: got rd_w=%0d wen_w=%0b expected %0d 1", rd_w, wen_w, e);
        else n_pass++;

        valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b1; rd_e = 5'd9; lsu_data_vld_m = 1'b0;
        exp_q.push_back(5'd9);
        tick();
        valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b0; rd_e = 5'd12; flush_e = 1'b1;
        tick();
        n_chk++;
        if (rd_m !== 5'd9 || wen_m !== 1'b1 || load_m !== 1'b1 || wen_w !== 1'b0)
            $display("FAIL flush_hold_m: got rd_m=%0d wen_m=%0b load_m=%0b wen_w=%0b expected 9 1 1 0",
                     rd_m, wen_m, load_m, wen_w);
        else n_pass++;
        lsu_data_vld_m = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (rd_w !== e || wen_w !== 1'b1 || wen_m !== 1'b0)
            $display("FAIL flush_retire: got rd_w=%0d wen_w=%0b wen_m=%0b expected %0d 1 0", rd_w, wen_w, wen_m, e);
        else n_pass++;
        idle_e();
        tick();

        valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b1; rd_e = 5'd4; lsu_data_vld_m = 1'b0;
        tick();
        idle_e();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        exp_lu = 16'd0;
        n_chk++;
        if (stall_e !== 1'b0 || wen_m !== 1'b0 || load_m !== 1'b0 || rd_m !== 5'd0 || lu_cnt !== 16'd0)
            $display("FAIL wait_reset_now: got stall_e=%0b wen_m=%0b load_m=%0b rd_m=%0d lu_cnt=%0h expected 0 0 0 0 0",
                     stall_e, wen_m, load_m, rd_m, lu_cnt);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        n_chk++;
        if (stall_e !== 1'b0 || wen_w !== 1'b0 || wen_m !== 1'b0)
            $display("FAIL wait_reset_after: got stall_e=%0b wen_w=%0b wen_m=%0b expected 0 0 0", stall_e, wen_w, wen_m);
        else n_pass++;
        lsu_data_vld_m = 1'b1;
    endtask
`else
    task automatic test_single_cycle_load();
        logic [4:0] e;
        exp_q.delete();
        valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b1; rd_e = 5'd3; lsu_data_vld_m = 1'b0;
        exp_q.push_back(5'd3);
        tick();
        idle_e();
        #1;
        n_chk++;
        if (stall_e !== 1'b0 || stall_d !== 1'b0 || load_m !== 1'b1)
            $display("FAIL nomacro_load_m: got stall_e=%0b stall_d=%0b load_m=%0b expected 0 0 1", stall_e, stall_d, load_m);
        else n_pass++;
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (rd_w !== e || wen_w !== 1'b1)
            $display("FAIL nomacro_retire: got rd_w=%0d wen_w=%0b expected %0d 1", rd_w, wen_w, e);
        else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        exp_lu = 16'd0;
        n_chk++;
        if (rd_w !== 5'd0 || wen_w !== 1'b0 || lu_cnt !== 16'd0)
            $display("FAIL async_reset: got rd_w=%0d wen_w=%0b lu_cnt=%0h expected 0 0 0", rd_w, wen_w, lu_cnt);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        lsu_data_vld_m = 1'b1;
    endtask
`endif

    task automatic test_saturate();
        resetn = 1'b0;
        lsu_data_vld_m = 1'b1;
        valid_e = 1'b1; wen_e = 1'b1; load_e = 1'b1; flush_e = 1'b0; rd_e = 5'd7;
        rs2_use_d = 1'b1; rs2_d = 5'd7; rs1_use_d = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        n_chk++;
        if (lu_cnt !== 16'hFFFE) $display("FAIL sat_fffe: got %0h expected fffe", lu_cnt);
        else n_pass++;
        tick();
        n_chk++;
        if (lu_cnt !== 16'hFFFF) $display("FAIL sat_ffff: got %0h expected ffff", lu_cnt);
        else n_pass++;
        tick();
        n_chk++;
        if (lu_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %0h expected ffff", lu_cnt);
        else n_pass++;
        idle_e();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd0();
        test_load_use();
        test_stream();
`ifdef CPU7_LSU_MULTICYCLE_EN
        test_lsu_wait();
`else
        test_single_cycle_load();
`endif
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu7_exu_eclwbpipe.md
CPU7_EXU_ECLWBPIPE -- requirements
Module: cpu7_exu_eclwbpipe

Interface
REQ-001 SHALL: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: valid_e  input  1  instruction in E is valid.
REQ-004 SHALL: rd_e  input  5  destination register of E instruction.
REQ-005 SHALL: wen_e  input  1  E instruction writes rd_e.
REQ-006 SHALL: load_e  input  1  E instruction is a load.
REQ-007 SHALL: flush_e  input  1  kill E instruction this cycle.
REQ-008 SHALL: rs1_d, rs2_d  input  5 each  D-stage source registers.
REQ-009 SHALL: rs1_use_d, rs2_use_d  input  1 each  D instruction reads rs1_d/rs2_d.
REQ-010 SHALL: lsu_data_vld_m  input  1  load data for M instruction available (used only with macro).
REQ-011 SHALL: rd_m, rd_w  output  5 each  registered destinations of M/W, feeding rs1/rs2 bypass select logic.
REQ-012 SHALL: wen_m, wen_w  output  1 each  registered write enables of M/W; wen_w is the RF write enable.
REQ-013 SHALL: load_m  output  1  M instruction is a load.
REQ-014 SHALL: stall_d  output  1  hold D (load-use or M wait).
REQ-015 SHALL: stall_e  output  1  hold E (M wait).
REQ-016 SHALL: lu_cnt  output  16  saturating load-use stall-cycle counter.

Function
REQ-017 SHALL: adv_m = ~stall_e; when adv_m, M <= {rd_e, wen_e & valid_e & ~flush_e & (rd_e!=0), load_e & valid_e & ~flush_e}.
REQ-018 SHALL: when ~adv_m, M registers hold; W <= bubble (wen_w=0, rd_w unchanged).
REQ-019 SHALL: when adv_m, W <= {rd_m, wen_m}; latency E->M one cycle, M->W one cycle.
REQ-020 SHALL: load_use = valid_e & load_e & ~flush_e & (rd_e!=0) & ((rs1_use_d & rs1_d==rd_e) | (rs2_use_d & rs2_d==rd_e)), combinational.
REQ-021 SHALL: stall_d = load_use | stall_e; stall_e = (state==WAIT_LSU) | (state==RUN & load_m & ~lsu_data_vld_m) with macro, else 0.
REQ-022 SHALL: flush_e never affects M or W contents already latched, including during WAIT_LSU.
REQ-023 SHALL: lu_cnt increments by 1 each cycle load_use & ~stall_e; holds at 16'hFFFF (no wrap).
REQ-024 SHALL: M-stage FSM states RUN, WAIT_LSU; RUN->WAIT_LSU when load_m & ~lsu_data_vld_m; WAIT_LSU->RUN when lsu_data_vld_m; else hold.
REQ-025 SHALL: lsu_data_vld_m in the same cycle a load first sits in M gives zero wait cycles.
REQ-026 SHALL: in the cycle WAIT_LSU exits (lsu_data_vld_m=1), stall_e=0 and M advances to W.

Reset
REQ-027 SHALL: on resetn=0, immediately: rd_m=rd_w=0, wen_m=wen_w=0, load_m=0, lu_cnt=0, state=RUN.
REQ-028 SHALL: reset asserted during WAIT_LSU aborts the wait; first cycle after release is RUN with empty M/W.

Configuration
REQ-029 SHALL: macro CPU7_LSU_MULTICYCLE_EN compiles in the FSM and lsu_data_vld_m use.
REQ-030 SHALL: without CPU7_LSU_MULTICYCLE_EN, lsu_data_vld_m is ignored, stall_e is constant 0, loads complete in one M cycle; all other behaviour identical.

Verification
REQ-031 SHALL: reset, then valid_e=1,wen_e=1,rd_e=5 -> next cycle rd_m=5,wen_m=1; following cycle rd_w=5,wen_w=1.
REQ-032 SHALL: rd_e=0,wen_e=1,valid_e=1 -> wen_m=0, wen_w=0.
REQ-033 SHALL: load_e=1,rd_e=7, rs2_use_d=1,rs2_d=7 -> stall_d=1 same cycle, lu_cnt 0->1 next cycle; rs2_d=8 -> stall_d=0.
REQ-034 SHALL: macro on, load rd=3 in M, lsu_data_vld_m low 2 cycles -> stall_e=stall_d=1 for 2 cycles, wen_w=0 those cycles, then rd_w=3,wen_w=1.
REQ-035 SHALL: flush_e=1 during WAIT_LSU -> M load still retires with wen_w=1; E instruction never reaches M (wen_m=0 after).
REQ-036 SHALL: force lu_cnt to 16'hFFFF via 65535 load-use cycles, one more load-use cycle -> lu_cnt stays 16'hFFFF.
